// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencer (pipeline_ctrl).
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StDrain  = 2'd2,
      StHalted = 2'd3
   } state_e;

   localparam int unsigned REG_ADDR_W_DEF = 5;
   localparam int unsigned DRAIN_CYC_DEF  = 4;
   localparam int unsigned ZERO_REG       = 0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stage-control outputs of the pipeline sequencer.
// master = datapath side, slave = pipeline_ctrl.
interface pipeline_ctrl_if import pipe_ctrl_pkg::*; #(
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int unsigned CNT_W      = 32
);
   logic                  enable;
   logic                  halt_req;
   logic                  ex_mem_read;
   logic [REG_ADDR_W-1:0] ex_rt;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_uses_rt;
   logic                  mem_branch;
   logic                  mem_zero;
   logic                  mem_jump;

   logic                  pc_en;
   logic                  ifid_en;
   logic                  ifid_flush;
   logic                  idex_en;
   logic                  idex_flush;
   logic                  exmem_flush;
   logic                  back_en;
   logic                  running;
   logic [CNT_W-1:0]      perf_stall_cnt;
   logic [CNT_W-1:0]      perf_flush_cnt;

   modport master (
      output enable, halt_req, ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt,
             mem_branch, mem_zero, mem_jump,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, back_en,
             running, perf_stall_cnt, perf_flush_cnt
   );

   modport slave (
      input  enable, halt_req, ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt,
             mem_branch, mem_zero, mem_jump,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, back_en,
             running, perf_stall_cnt, perf_flush_cnt
   );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use and control-redirect detection for pipeline_ctrl.
module hazard_detect import pipe_ctrl_pkg::*; #(
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic                  mem_branch,
   input  logic                  mem_zero,
   input  logic                  mem_jump,
   output logic                  lu,
   output logic                  redirect
);

   localparam logic [REG_ADDR_W-1:0] ZeroIdx = REG_ADDR_W'(ZERO_REG);

   always_comb begin
      redirect = mem_jump | (mem_branch & mem_zero);
      // Loads into $zero never create a dependency.
      lu = ex_mem_read & (ex_rt != ZeroIdx) &
           ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: per-stage enables/flushes and run/drain/halt FSM.
// Performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl import pipe_ctrl_pkg::*; #(
   parameter int unsigned DRAIN_CYC  = DRAIN_CYC_DEF,
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int unsigned CNT_W      = 32
) (
   input logic            clk,
   input logic            arst,
   pipeline_ctrl_if.slave bus
);

   localparam int unsigned   DcW       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DcW-1:0] DrainLoad = DcW'(DRAIN_CYC - 1);

   state_e           state_q, state_d;
   logic [DcW-1:0]   drain_cnt_q, drain_cnt_d;
   logic             lu, redirect, stall, active;

   hazard_detect #(
      .REG_ADDR_W(REG_ADDR_W)
   ) u_hazard (
      .ex_mem_read(bus.ex_mem_read),
      .ex_rt      (bus.ex_rt),
      .id_rs      (bus.id_rs),
      .id_rt      (bus.id_rt),
      .id_uses_rt (bus.id_uses_rt),
      .mem_branch (bus.mem_branch),
      .mem_zero   (bus.mem_zero),
      .mem_jump   (bus.mem_jump),
      .lu         (lu),
      .redirect   (redirect)
   );

   // A squashed ID instruction needs no stall.
   assign stall  = lu & ~redirect;
   assign active = (state_q == StRun) || (state_q == StDrain);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q     <= StIdle;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      case (state_q)
         StIdle:   if (bus.enable) state_d = StRun;
         StRun: begin
            if (bus.halt_req || !bus.enable) begin
               state_d     = StDrain;
               drain_cnt_d = DrainLoad;
            end
         end
         StDrain: begin
            if (drain_cnt_q == '0) state_d = StHalted;
            else                   drain_cnt_d = drain_cnt_q - 1'b1;
         end
         StHalted: if (bus.enable && !bus.halt_req) state_d = StRun;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.pc_en       = 1'b0;
      bus.ifid_en     = 1'b0;
      bus.ifid_flush  = 1'b0;
      bus.idex_en     = 1'b0;
      bus.idex_flush  = 1'b0;
      bus.exmem_flush = 1'b0;
      bus.back_en     = 1'b0;
      bus.running     = active;
      case (state_q)
         StRun: begin
            bus.pc_en       = ~stall;
            bus.ifid_en     = ~stall;
            bus.ifid_flush  = redirect;
            bus.idex_en     = 1'b1;
            bus.idex_flush  = redirect | stall;
            bus.exmem_flush = redirect;
            bus.back_en     = 1'b1;
         end
         StDrain: begin
            // IF fetches bubbles; a redirect still loads the PC so resume starts at the target.
            bus.pc_en       = redirect;
            bus.ifid_en     = ~stall;
            bus.ifid_flush  = ~stall;
            bus.idex_en     = 1'b1;
            bus.idex_flush  = redirect | stall;
            bus.exmem_flush = redirect;
            bus.back_en     = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (active && stall && !(&stall_cnt_q))    stall_cnt_q <= stall_cnt_q + 1'b1;
         if (active && redirect && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign bus.perf_stall_cnt = stall_cnt_q;
   assign bus.perf_flush_cnt = flush_cnt_q;
`else
   assign bus.perf_stall_cnt = {CNT_W{1'b0}};
   assign bus.perf_flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Replaces the single global `enable` with per-stage register enables and flush (bubble) controls.
- Detects load-use hazards and stalls for them.
- Squashes wrong-path instructions when a branch or jump resolves in MEM.
- Runs a run/drain/halt state machine so a stop request lets in-flight instructions retire before the core freezes.

Parameters:
- DRAIN_CYC, 4, cycles of downstream-only execution after a stop request (IF frozen); covers ID..WB.
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  main clock
- arst  in  1  asynchronous active-high reset
- enable  in  1  run request from the host (level)
- halt_req  in  1  one-cycle stop request (e.g. from a halt-opcode decode in ID)
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  REG_ADDR_W  destination register of the load in EX
- id_rs  in  REG_ADDR_W  source register rs of the instruction in ID
- id_rt  in  REG_ADDR_W  source register rt of the instruction in ID
- id_uses_rt  in  1  instruction in ID reads rt (R-type, store, branch)
- mem_branch  in  1  branch in MEM
- mem_zero  in  1  zero flag in MEM
- mem_jump  in  1  jump in MEM
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  load bubble (all zero) into IF/ID
- idex_en  out  1  ID/EX register enable
- idex_flush  out  1  load bubble into ID/EX
- exmem_flush  out  1  load bubble into EX/MEM
- back_en  out  1  enable for EX/MEM and MEM/WB
- running  out  1  FSM in RUN or DRAIN
- perf_stall_cnt  out  CNT_W  load-use stall cycles
- perf_flush_cnt  out  CNT_W  redirect events

Behaviour:
- Reset: asynchronous, active-high. Reset clears the state to IDLE, drain_cnt to 0 and both counters to 0. While arst is high every output is 0.
- States:
  - IDLE: all enables 0. enable=1 moves to RUN on the next edge.
  - RUN: all enables 1 unless a hazard rule below overrides them. halt_req=1 or enable=0 moves to DRAIN and loads drain_cnt=DRAIN_CYC-1.
  - DRAIN: pc_en=0, ifid_en=1 and ifid_flush=1, so bubbles are fetched. idex_en=1 and back_en=1. drain_cnt decrements each cycle; when it reaches 0 the FSM moves to HALTED.
  - HALTED: all enables 0. enable=1 together with halt_req=0 moves to RUN. The PC is preserved, so execution resumes at the next unfetched instruction.
- Redirect:
  - Condition: redirect = mem_jump | (mem_branch & mem_zero). Inputs are registered pipeline state and are decoded combinationally in the same cycle.
  - RUN: pc_en=1 (the PC loads the target). ifid_flush, idex_flush and exmem_flush are all 1, squashing the 3 wrong-path instructions.
  - DRAIN: pc_en=1 for that cycle only, so the target is captured for the resume; the same three flushes apply.
- Load-use:
  - Condition: lu = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
  - Effect: pc_en=0, ifid_en=0 (hold), idex_flush=1, back_en=1. This lasts exactly one cycle, because the load then leaves EX.
- Priority: redirect > lu. When both are true, the lu stall is suppressed, because the ID instruction is being squashed anyway.
- Simultaneous events: halt_req while lu is true still enters DRAIN next cycle, and the current cycle applies the lu stall. A halt_req in a DRAIN or HALTED state is ignored.
- Latency: all control outputs are combinational from the state and inputs in the same cycle. State transitions take 1 cycle.
- Reset mid-operation: the FSM returns to IDLE immediately, pipeline enables drop and no partial drain occurs.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined:
  - perf_stall_cnt increments on each cycle with lu & ~redirect while the state is RUN or DRAIN.
  - perf_flush_cnt increments on each redirect cycle.
  - Both counters saturate at all-ones and clear only on arst.
- When undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, HALTED; 2-bit encoding);
  - the REG_ADDR_W default;
  - the DRAIN_CYC default;
  - a constant for the zero register index.
- One natural sub-module, hazard_detect: purely combinational. It computes lu and redirect, and pipeline_ctrl instantiates it. The FSM, counters and output muxing stay in the top.

Test Plan:
- Reset then start: arst=1 for 3 cycles with enable=1 → all outputs 0. Release arst → IDLE, then RUN at the next edge; pc_en=ifid_en=idex_en=back_en=1 and running=1.
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 → one cycle with pc_en=0, ifid_en=0, idex_flush=1. The next cycle (ex_mem_read=0) shows normal enables; perf_stall_cnt=1 (macro on).
- Zero register / unused rt: ex_rt=0, id_rs=0 → no stall. ex_rt=9, id_rt=9, id_uses_rt=0 → no stall.
- Branch taken with concurrent lu: mem_branch=1, mem_zero=1 together with an lu match → pc_en=1, the three flushes asserted, ifid_en=1; perf_flush_cnt=1, perf_stall_cnt unchanged.
- Drain: halt_req pulse in RUN → 4 cycles with pc_en=0, ifid_flush=1, back_en=1, then HALTED with all enables 0. enable held at 1 and halt_req=0 → RUN the next cycle.
- Reset mid-drain: arst asserted at drain cycle 2 → outputs 0 immediately. After release the FSM is in IDLE and the counters read 0.
